// File: rtl/i2s_rx_framer.sv
// I2S receive framer: samples SCK/WS/SD in the clk_i domain and assembles left/right words.
// Define I2S_RX_SYNC_EN to add a two-flop synchroniser on sck_i, ws_i and sd_i.
module i2s_rx_framer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sck_i,
    input  logic                  ws_i,
    input  logic                  sd_i,
    output logic [CNT_WIDTH-1:0]  bit_idx_o,
    output logic                  bit_we_o,
    output logic [DATA_WIDTH-1:0] left_o,
    output logic [DATA_WIDTH-1:0] right_o,
    output logic                  valid_o,
    output logic                  chan_o
);
    localparam logic [CNT_WIDTH-1:0] MaxIdx = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH:0]   DataW  = (CNT_WIDTH + 1)'(DATA_WIDTH);

    typedef enum logic {StIdle, StShift} state_e;

    // {sck, ws, sd} as seen by the edge detector
    logic [2:0] pins_s;

`ifdef I2S_RX_SYNC_EN
    logic [2:0] meta_q;
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {sck_i, ws_i, sd_i};
            sync_q <= meta_q;
        end
    end

    assign pins_s = sync_q;
`else
    assign pins_s = {sck_i, ws_i, sd_i};
`endif

    logic [2:0]            pins_q;
    logic                  sck_prev_q;
    logic                  ws_last_q;
    logic                  primed_q;
    state_e                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  chan_q;

    logic                  sck_rise;
    logic                  ws_s;
    logic                  sd_s;
    logic                  ws_edge;
    logic [DATA_WIDTH-1:0] word_upd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pins_q     <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            pins_q     <= pins_s;
            sck_prev_q <= pins_q[2];
        end
    end

    assign sck_rise = pins_q[2] & ~sck_prev_q;
    assign ws_s     = pins_q[1];
    assign sd_s     = pins_q[0];
    // The first SCK rise after reset only seeds ws_last_q, so a reset released
    // mid-frame cannot start capturing in the middle of a word.
    assign ws_edge  = sck_rise & primed_q & (ws_s != ws_last_q);

    always_comb begin
        bit_we_o  = sck_rise & (state_q == StShift) & ({1'b0, cnt_q} < DataW);
        bit_idx_o = bit_we_o ? (MaxIdx - cnt_q) : '0;
        word_upd  = word_q;
        if (bit_we_o) begin
            word_upd[bit_idx_o] = sd_s;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ws_last_q <= 1'b0;
            primed_q  <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            word_q    <= '0;
            chan_q    <= 1'b0;
            left_o    <= '0;
            right_o   <= '0;
            valid_o   <= 1'b0;
            chan_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (sck_rise) begin
                ws_last_q <= ws_s;
                primed_q  <= 1'b1;
                unique case (state_q)
                    StIdle: begin
                        if (ws_edge) begin
                            state_q <= StShift;
                            cnt_q   <= '0;
                            word_q  <= '0;
                            chan_q  <= ws_s;
                        end
                    end
                    StShift: begin
                        if (ws_edge) begin
                            // This rise still carries the finishing word's last slot.
                            if (chan_q) begin
                                right_o <= word_upd;
                            end else begin
                                left_o <= word_upd;
                            end
                            chan_o  <= chan_q;
                            valid_o <= 1'b1;
                            cnt_q   <= '0;
                            word_q  <= '0;
                            chan_q  <= ws_s;
                        end else begin
                            word_q <= word_upd;
                            if (cnt_q != CntMax) begin
                                cnt_q <= cnt_q + CNT_WIDTH'(1);
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_framer.sv
// Directed bench for i2s_rx_framer: full/short frames, mid-frame resets, publish latency.
// Publish latency expectation follows I2S_RX_SYNC_EN.
module tb_i2s_rx_framer;
    localparam int unsigned DW = 24;
    localparam int unsigned CW = 5;
`ifdef I2S_RX_SYNC_EN
    localparam int Lat = 5;
`else
    localparam int Lat = 3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sck = 1'b0;
    logic          ws  = 1'b0;
    logic          sd  = 1'b0;
    logic [CW-1:0] bit_idx;
    logic          bit_we;
    logic [DW-1:0] left;
    logic [DW-1:0] right;
    logic          valid;
    logic          chan;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int edge_cyc = 0;
    int dbl_valid = 0;
    logic valid_prev = 1'b0;
    logic last_ws = 1'b0;
    logic prev_last = 1'b0;

    int            ev_chan[$];
    logic [DW-1:0] ev_left[$];
    logic [DW-1:0] ev_right[$];
    int            ev_lat[$];
    int            we_idx[$];

    int            exp_chan[9]  = '{0, 1, 0, 1, 0, 0, 1, 1, 0};
    logic [DW-1:0] exp_left[9]  = '{24'hA5A5A5, 24'hA5A5A5, 24'hBEEF00, 24'hBEEF00, 24'h111111,
                                    24'h333333, 24'h333333, 24'h000000, 24'h666666};
    logic [DW-1:0] exp_right[9] = '{24'h000000, 24'h123456, 24'h123456, 24'hCAFE00, 24'hCAFE00,
                                    24'h000000, 24'h444444, 24'h555555, 24'h555555};

    always #5 clk = ~clk;

    i2s_rx_framer #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .sck_i    (sck),
        .ws_i     (ws),
        .sd_i     (sd),
        .bit_idx_o(bit_idx),
        .bit_we_o (bit_we),
        .left_o   (left),
        .right_o  (right),
        .valid_o  (valid),
        .chan_o   (chan)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid) begin
            ev_chan.push_back(int'(chan));
            ev_left.push_back(left);
            ev_right.push_back(right);
            ev_lat.push_back(cyc - edge_cyc);
        end
        if (valid && valid_prev) dbl_valid = dbl_valid + 1;
        valid_prev = valid;
        if (bit_we) we_idx.push_back(int'(bit_idx));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_left"}, 32'(left), 32'h0);
        chk({tag, "_right"}, 32'(right), 32'h0);
        chk({tag, "_valid"}, 32'(valid), 32'h0);
        chk({tag, "_chan"}, 32'(chan), 32'h0);
        chk({tag, "_we"}, 32'(bit_we), 32'h0);
        chk({tag, "_idx"}, 32'(bit_idx), 32'h0);
    endtask

    // One SCK period: WS/SD change while SCK is low, then SCK rises.
    task automatic rise(input logic w, input logic d);
        ws = w;
        sd = d;
        tick(4);
        sck = 1'b1;
        if (w != last_ws) edge_cyc = cyc;
        last_ws = w;
        tick(4);
        sck = 1'b0;
    endtask

    // Rises first..last of an n-rise channel frame; v is the slot data left-justified.
    // Rise 0 carries the previous frame's last slot bit.
    task automatic send_slot(input logic ch, input int n, input logic [31:0] v,
                             input int first, input int last);
        for (int k = first; k <= last; k++) begin
            rise(ch, (k == 0) ? prev_last : v[32-k]);
        end
        if (last == n - 1) prev_last = v[32-n];
    endtask

    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        @(negedge clk);
        chk_zero(tag);
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        int bad;
        int n;

        tick(3);
        chk_zero("reset");
        rst = 1'b0;
        tick(3);

        // 32-SCK frames, 24-bit words
        we_idx.delete();
        send_slot(1'b1, 32, 32'h0, 0, 31);
        send_slot(1'b0, 32, 32'hA5A5A500, 0, 31);
        send_slot(1'b1, 32, 32'h12345600, 0, 31);
        tick(2);
        chk("we_count_full", 32'(we_idx.size()), 32'd48);
        bad = 0;
        n = (we_idx.size() < 48) ? we_idx.size() : 48;
        for (int i = 0; i < n; i++) begin
            if (we_idx[i] != 23 - (i % 24)) bad++;
        end
        chk("we_idx_order", 32'(bad), 32'd0);
        chk("ev_count_a", 32'(ev_chan.size()), 32'd1);

        // 16-SCK frames: short words padded with zero LSBs
        we_idx.delete();
        send_slot(1'b0, 16, 32'hBEEF0000, 0, 15);
        send_slot(1'b1, 16, 32'hCAFE0000, 0, 15);
        chk("we_count_short", 32'(we_idx.size()), 32'd31);

        // Reset mid right frame
        send_slot(1'b0, 32, 32'h11111100, 0, 31);
        send_slot(1'b1, 32, 32'h22222200, 0, 9);
        rst_pulse("rst_mid_right");
        chk("ev_count_c", 32'(ev_chan.size()), 32'd5);
        send_slot(1'b1, 32, 32'h22222200, 10, 31);
        send_slot(1'b0, 32, 32'h33333300, 0, 31);
        send_slot(1'b1, 32, 32'h44444400, 0, 31);

        // Reset released mid left frame
        send_slot(1'b0, 32, 32'h77777700, 0, 9);
        rst_pulse("rst_mid_left");
        chk("ev_count_d", 32'(ev_chan.size()), 32'd7);
        send_slot(1'b0, 32, 32'h77777700, 10, 31);
        send_slot(1'b1, 32, 32'h55555500, 0, 31);
        send_slot(1'b0, 32, 32'h66666600, 0, 31);
        send_slot(1'b1, 32, 32'h0, 0, 0);
        tick(10);

        chk("ev_count", 32'(ev_chan.size()), 32'd9);
        n = (ev_chan.size() < 9) ? ev_chan.size() : 9;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("ev%0d_chan", i), 32'(ev_chan[i]), 32'(exp_chan[i]));
            chk($sformatf("ev%0d_left", i), 32'(ev_left[i]), 32'(exp_left[i]));
            chk($sformatf("ev%0d_right", i), 32'(ev_right[i]), 32'(exp_right[i]));
            chk($sformatf("ev%0d_latency", i), 32'(ev_lat[i]), 32'(Lat));
        end
        chk("valid_single_clk", 32'(dbl_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
